byte_serial_adder: RTL



---
 rtl/byte_serial_adder_pkg.sv | 19 +
 rtl/byte_serial_adder_byte_add.sv | 19 +
 rtl/byte_serial_adder.sv | 117 +++++++++++
 3 files changed

// File: rtl/byte_serial_adder_pkg.sv
// Shared constants for the byte-serial multi-byte adder:
// FSM state encodings, byte width and an index-width helper.
package byte_serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int BYTE_W = 8;

  // Bits needed to index n bytes; never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/byte_serial_adder_byte_add.sv
// Existing 8-bit byte adder: purely combinational A+B+carry-in.
// Ports: i_a, i_b (bytes), i_cin -> o_sum (byte), o_cout.
module byte_serial_adder_byte_add
  import byte_serial_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_cout
);

  logic [BYTE_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{BYTE_W{1'b0}}, i_cin};
  assign o_sum  = w_full[BYTE_W-1:0];
  assign o_cout = w_full[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// N-byte adder using one 8-bit byte adder, LSB first, one byte per cycle.
// Ports: clk, rst (async high), start, a, b, cin -> busy, done, sum, cout.
// Optional BYTE_SERIAL_SUB_EN adds input sub: result becomes a-b, cout=1
// meaning no borrow.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef BYTE_SERIAL_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  logic [1:0]        r_state;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;
  logic [W-1:0]      r_sum;
  logic              r_cout;

  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_raw;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_sum_byte;
  logic              w_cout;
  logic              w_init_carry;

  assign w_a_byte = r_a[{r_idx, 3'b000} +: BYTE_W];
  assign w_b_raw  = r_b[{r_idx, 3'b000} +: BYTE_W];

`ifdef BYTE_SERIAL_SUB_EN
  logic r_sub;

  // Two's complement subtract: invert B, seed carry with 1.
  assign w_b_byte     = w_b_raw ^ {BYTE_W{r_sub}};
  assign w_init_carry = sub | cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sub <= 1'b0;
    else if (r_state == S_IDLE && start)
      r_sub <= sub;
  end
`else
  assign w_b_byte     = w_b_raw;
  assign w_init_carry = cin;
`endif

  byte_serial_adder_byte_add u_byte_add (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_sum_byte),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_init_carry;
            r_idx   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[{r_idx, 3'b000} +: BYTE_W] <= w_sum_byte;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_cout  <= w_cout;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == S_ADD);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
